// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-bounded arbiter sharing one FIFO write port.
// Define FIFO_WR_ARB_PRIO0_EN to give requester 0 strict priority at each IDLE arbitration.
module fifo_wr_arbiter #(
   parameter int data_width = 8,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic                          wr_clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*data_width-1:0] req_data,
   input  logic                          fifo_full,
   output logic [NUM_REQ-1:0]            ack,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          fifo_wr_en,
   output logic [data_width-1:0]         fifo_w_data,
   output logic                          busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t             state, state_n;
   logic [NUM_REQ-1:0] grant_n;
   logic [IW-1:0]      gidx, gidx_n;
   logic [IW-1:0]      rr_ptr, rr_n;
   logic [CW-1:0]      count, count_n;
   logic [IW-1:0]      winner, scan_sel;
   logic               found;
   logic               accept;
   int                 scan_idx;

   // Only the owner's own req and fifo_full gate a write; data never feeds control.
   assign accept = (state == BURST) && req[gidx] && !fifo_full;

   always_ff @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         grant  <= '0;
         gidx   <= '0;
         count  <= '0;
         rr_ptr <= IW'(NUM_REQ - 1);
      end else begin
         state  <= state_n;
         grant  <= grant_n;
         gidx   <= gidx_n;
         count  <= count_n;
         rr_ptr <= rr_n;
      end
   end

   always_comb begin
      state_n  = state;
      grant_n  = grant;
      gidx_n   = gidx;
      count_n  = count;
      rr_n     = rr_ptr;
      winner   = rr_ptr;
      found    = 1'b0;
      scan_idx = 0;
      scan_sel = '0;
      // Scan upward from the slot after the last winner, wrapping at NUM_REQ.
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
         scan_sel = IW'(scan_idx);
         if (!found && req[scan_sel]) begin
            winner = scan_sel;
            found  = 1'b1;
         end
      end
`ifdef FIFO_WR_ARB_PRIO0_EN
      if (req[0]) winner = '0;
`else
`endif
      case (state)
         IDLE: begin
            if (|req) begin
               state_n = BURST;
               grant_n = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
               gidx_n  = winner;
               rr_n    = winner;
               count_n = '0;
            end
         end
         BURST: begin
            if (!req[gidx] || (accept && count == LAST_CNT)) begin
               state_n = IDLE;
               grant_n = '0;
               count_n = '0;
            end else if (accept) begin
               count_n = count + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
   end

   always_comb begin
      ack         = '0;
      fifo_wr_en  = accept;
      busy        = (state == BURST);
      fifo_w_data = '0;
      if (accept) ack[gidx] = 1'b1;
      if (|grant) fifo_w_data = req_data[gidx*data_width +: data_width];
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed vector bench for fifo_wr_arbiter (4 requesters, burst 4).
module tb_fifo_wr_arbiter;

   typedef struct packed {
      logic [3:0]  req;
      logic [31:0] data;
      logic        full;
      logic [3:0]  ack;
      logic [3:0]  grant;
      logic        wr_en;
      logic [7:0]  wdata;
      logic        busy;
   } vec_t;

   logic        wr_clk;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic        fifo_full;
   logic [3:0]  ack;
   logic [3:0]  grant;
   logic        fifo_wr_en;
   logic [7:0]  fifo_w_data;
   logic        busy;

   int          n_tests;
   int          n_fail;
   vec_t        vecs [10];
   logic [31:0] dconst;

   fifo_wr_arbiter #(.data_width(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
      .wr_clk      (wr_clk),
      .reset       (reset),
      .req         (req),
      .req_data    (req_data),
      .fifo_full   (fifo_full),
      .ack         (ack),
      .grant       (grant),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_w_data (fifo_w_data),
      .busy        (busy)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic do_reset();
      req       = '0;
      fifo_full = 1'b0;
      reset     = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   // One IDLE arbitration cycle followed by n accepted words from requester idx.
   task automatic do_burst(input string name, input int idx, input int n);
      @(negedge wr_clk);
      chk({name, " idle busy"}, busy, 0);
      chk({name, " idle grant"}, grant, 0);
      next_cycle();
      for (int w = 0; w < n; w++) begin
         @(negedge wr_clk);
         chk({name, " grant"}, grant, 4'b0001 << idx);
         chk({name, " ack"}, ack, 4'b0001 << idx);
         chk({name, " wr_en"}, fifo_wr_en, 1);
         chk({name, " wdata"}, fifo_w_data, dconst[idx*8 +: 8]);
         next_cycle();
      end
   endtask

   initial begin
      int acks;
      n_tests   = 0;
      n_fail    = 0;
      dconst    = 32'hD3C2B1A0;
      req       = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      reset     = 1'b1;

      //            req      data    full ack      grant    wr    wdata  busy
      vecs[0] = '{4'b0001, 32'hA0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{4'b0001, 32'hA0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA0, 1'b1};
      vecs[2] = '{4'b0001, 32'hA1, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA1, 1'b1};
      vecs[3] = '{4'b0001, 32'hA2, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA2, 1'b1};
      vecs[4] = '{4'b0001, 32'hA3, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA3, 1'b1};
      vecs[5] = '{4'b0001, 32'hA4, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
      vecs[6] = '{4'b0001, 32'hA4, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA4, 1'b1};
      vecs[7] = '{4'b0001, 32'hA5, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA5, 1'b1};
      vecs[8] = '{4'b0000, 32'hA5, 1'b0, 4'b0000, 4'b0001, 1'b0, 8'hA5, 1'b1};
      vecs[9] = '{4'b0000, 32'hA5, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};

      // Reset state while every requester is asking.
      req = 4'b1111;
      @(negedge wr_clk);
      chk("reset grant", grant, 0);
      chk("reset ack", ack, 0);
      chk("reset wr_en", fifo_wr_en, 0);
      chk("reset busy", busy, 0);
      do_reset();

      // Single requester streaming 0xA0..0xA5.
      for (int i = 0; i < 10; i++) begin
         req       = vecs[i].req;
         req_data  = vecs[i].data;
         fifo_full = vecs[i].full;
         @(negedge wr_clk);
         chk($sformatf("vec%0d ack", i), ack, vecs[i].ack);
         chk($sformatf("vec%0d grant", i), grant, vecs[i].grant);
         chk($sformatf("vec%0d wr_en", i), fifo_wr_en, vecs[i].wr_en);
         chk($sformatf("vec%0d wdata", i), fifo_w_data, vecs[i].wdata);
         chk($sformatf("vec%0d busy", i), busy, vecs[i].busy);
         next_cycle();
      end

      req_data = dconst;
      do_reset();
      req = 4'b1111;
`ifdef FIFO_WR_ARB_PRIO0_EN
      do_burst("prio0 b0", 0, 4);
      do_burst("prio0 b1", 0, 4);
      do_burst("prio0 b2", 0, 4);
      req = 4'b1110;
      do_burst("prio rr1", 1, 4);
      do_burst("prio rr2", 2, 4);
      do_burst("prio rr3", 3, 4);
      do_burst("prio rr1b", 1, 4);
`else
      do_burst("rr b0", 0, 4);
      do_burst("rr b1", 1, 4);
      do_burst("rr b2", 2, 4);
      do_burst("rr b3", 3, 4);
      do_burst("rr b4", 0, 4);
`endif

      // FIFO full stalls requester 2 after its second word.
      do_reset();
      req = 4'b0100;
      do_burst("full pre", 2, 2);
      fifo_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge wr_clk);
         chk("full wr_en", fifo_wr_en, 0);
         chk("full ack", ack, 0);
         chk("full grant", grant, 4'b0100);
         next_cycle();
      end
      fifo_full = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge wr_clk);
         chk("full post ack", ack, 4'b0100);
         chk("full post wdata", fifo_w_data, 8'hC2);
         next_cycle();
      end
      req = 4'b0000;
      @(negedge wr_clk);
      chk("full end grant", grant, 0);
      chk("full end busy", busy, 0);
      next_cycle();

      // Requester 1 releases after two words.
      do_reset();
      req  = 4'b0010;
      acks = 0;
      next_cycle();
      for (int i = 0; i < 2; i++) begin
         @(negedge wr_clk);
         if (ack[1]) acks++;
         next_cycle();
      end
      req = 4'b1101;
      @(negedge wr_clk);
      if (ack[1]) acks++;
      chk("drop grant held", grant, 4'b0010);
      chk("drop wr_en", fifo_wr_en, 0);
      chk("drop burst len", acks, 2);
      next_cycle();
      req = 4'b1111;
      @(negedge wr_clk);
      chk("drop idle grant", grant, 0);
      chk("drop idle busy", busy, 0);
      next_cycle();
      @(negedge wr_clk);
      chk("drop next winner", grant, 4'b0100);
      next_cycle();

      // Asynchronous reset mid-burst.
      do_reset();
      req = 4'b1111;
      next_cycle();
      @(negedge wr_clk);
      chk("ares pre grant", grant, 4'b0001);
      next_cycle();
      #2;
      reset = 1'b1;
      #1;
      chk("ares wr_en", fifo_wr_en, 0);
      chk("ares ack", ack, 0);
      chk("ares grant", grant, 0);
      next_cycle();
      reset = 1'b0;
      @(negedge wr_clk);
      chk("ares idle grant", grant, 0);
      next_cycle();
      @(negedge wr_clk);
      chk("ares first grant", grant, 4'b0001);
      chk("ares first ack", ack, 4'b0001);
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of one async_fifo instance among NUM_REQ write-side requesters, all in the wr_clk domain.
- Round-robin arbitration with bounded bursts: a granted requester keeps the port for up to MAX_BURST accepted words.
- Drives fifo_wr_en/fifo_w_data and never asserts fifo_wr_en while fifo_full is high, so FIFO overflow cannot occur.

Parameters:
- data_width, 8, width of each requester word and of fifo_w_data
- NUM_REQ, 4, number of requesters (2..8)
- MAX_BURST, 4, maximum words accepted per grant (1..16)

Ports:
- wr_clk  input  1  write-domain clock; same clock as the FIFO write side
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester request; held high while the requester has a word on req_data
- req_data  input  NUM_REQ*data_width  requester i word at bits [i*data_width +: data_width]
- fifo_full  input  1  full flag from the FIFO write side
- ack  output  NUM_REQ  one-hot; ack[i]=1 means requester i's word is written at this wr_clk edge
- grant  output  NUM_REQ  one-hot registered current owner; all zero when idle
- fifo_wr_en  output  1  FIFO write enable
- fifo_w_data  output  data_width  word from the granted requester
- busy  output  1  high in BURST state

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - state=IDLE, grant=0, burst count=0, rr pointer=NUM_REQ-1, so requester 0 wins first.
  - Combinationally ack=0, fifo_wr_en=0, busy=0.
- State IDLE:
  - If req==0, remain in IDLE.
  - Otherwise choose the first requester with req=1, scanning upward (modulo NUM_REQ) from rr pointer+1.
  - At the next edge: grant=onehot(winner), rr pointer=winner, count=0, state=BURST.
  - Arbitration latency is 1 cycle; no word is accepted in IDLE.
- State BURST, g = granted index:
  - accept = req[g] & ~fifo_full.
  - fifo_wr_en=accept, ack[g]=accept, all other ack bits 0.
  - fifo_w_data = req_data slice g whenever grant≠0, 0 otherwise.
  - Each accepted word increments count.
- Exit BURST to IDLE (grant cleared at that edge) when either:
  - accept=1 and count==MAX_BURST-1, i.e. the burst limit is reached on this word; or
  - req[g]=0, i.e. the requester released without a write that cycle.
- fifo_full high in BURST:
  - Hold grant and count, write nothing, no timeout.
  - Requester g keeps ownership until it writes or drops req.
- Requests from other requesters during BURST are ignored until the return to IDLE; they are served in round-robin order after that.
- Outputs ack, fifo_wr_en and fifo_w_data are combinational from registered state plus req/fifo_full. There is no combinational path from req_data to any control output.
- Burst count width: clog2(MAX_BURST)+1 bits; it never wraps.
- Throughput per grant:
  - Up to MAX_BURST words, followed by 1 idle arbitration cycle.
  - Peak efficiency is MAX_BURST/(MAX_BURST+1).
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,NUM_REQ-1,0,...

Optional Feature:
- Macro: FIFO_WR_ARB_PRIO0_EN
- Defined:
  - In IDLE, requester 0 wins whenever req[0]=1, regardless of rr pointer.
  - When req[0]=0, requesters 1..NUM_REQ-1 are served round-robin and the rr pointer updates as normal.
  - A burst in progress is never preempted.
- Undefined: pure round-robin across all NUM_REQ requesters, as described in Behaviour.

Test Plan:
- Reset, then req=4'b0001 with data 0xA0..0xA5 held continuously, fifo_full=0:
  - 1 idle cycle, then 4 writes 0xA0..0xA3 with ack[0] high, grant drops, 1 IDLE cycle.
  - Next burst writes 0xA4, 0xA5.
- req=4'b1111 held, fifo_full=0: grant sequence 0001, 0010, 0100, 1000, 0001, each burst exactly 4 words; busy low for exactly 1 cycle between bursts.
- Requester 2 granted, fifo_full forced high for 5 cycles after its 2nd word:
  - fifo_wr_en=0 and ack=0 throughout, grant stays 0100.
  - After full deasserts, words 3 and 4 are written and the burst ends.
- Requester 1 drops req after 2 words: grant clears at the next edge, burst length is 2, and the next IDLE arbitration starts at requester 2.
- Assert reset for 1 cycle mid-burst, asynchronously between edges: fifo_wr_en, ack and grant go 0 immediately; after release, req=4'b1111 is granted to requester 0 first.
- With FIFO_WR_ARB_PRIO0_EN defined and req=4'b1111 held: every grant goes to requester 0 (0001 repeating). Dropping req[0] gives grants 0010, 0100, 1000 rotating.
